// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_pkg : shared widths and encodings for the integer pipeline
// Revision : 1.0
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_align : big-endian load lane select and zero/sign extension
// Revision   : 1.0
// ---------------------------------------------------------------------------
module load_align (
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);
  import pipe_pkg::*;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Byte 0 of the big-endian word sits in the most significant byte;
  // addr_lo[1] is the architectural address bit 30.
  always_comb begin
    byte_lane = raw[31:24];
    case (addr_lo)
      2'd0:    byte_lane = raw[31:24];
      2'd1:    byte_lane = raw[23:16];
      2'd2:    byte_lane = raw[15:8];
      default: byte_lane = raw[7:0];
    endcase
    half_lane = addr_lo[1] ? raw[15:0] : raw[31:16];
  end

  always_comb begin
    data = raw;
    case (size)
      MEM_SIZE_BYTE: data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      MEM_SIZE_HALF: data = {{16{sign_ext & half_lane[15]}}, half_lane};
      default:       data = raw;
    endcase
  end

endmodule : load_align
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_stage : MEM/WB pipeline register and writeback select.
//            Optional retire counter enabled by WB_RETIRE_COUNT_EN.
// Revision : 1.0
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_wb,
  input  logic              flush_mem,
  input  logic              valid_mem,
  input  logic              regWrite_mem,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic [1:0]        wb_sel_mem,
  input  logic [1:0]        mem_size_mem,
  input  logic              load_signed_mem,
  input  logic [1:0]        addr_lo_mem,
  input  logic [XLEN-1:0]   alu_result_mem,
  input  logic [XLEN-1:0]   load_data_mem,
  input  logic [XLEN-1:0]   pc_plus8_mem,
  output logic              valid_wb,
  output logic              regWrite_wb,
  output logic [REG_AW-1:0] rd_wb,
  output logic [XLEN-1:0]   wb_data
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [31:0]       retire_count,
  output logic              retire_pulse
`endif
);
  import pipe_pkg::*;

  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] wb_data_next;
  logic            capture;

  load_align u_load_align (
    .raw      (load_data_mem),
    .size     (mem_size_mem),
    .sign_ext (load_signed_mem),
    .addr_lo  (addr_lo_mem),
    .data     (load_ext)
  );

  always_comb begin
    wb_data_next = '0;
    case (wb_sel_mem)
      WB_SEL_ALU:  wb_data_next = alu_result_mem;
      WB_SEL_LOAD: wb_data_next = load_ext;
      WB_SEL_LINK: wb_data_next = pc_plus8_mem;
      default:     wb_data_next = '0;
    endcase
  end

  assign capture = !flush_mem && !stall_wb;

  // r0 writes are dropped here so the forwarding compare can never hit r0.
  always_ff @(posedge clk) begin
    if (reset || flush_mem) begin
      valid_wb    <= 1'b0;
      regWrite_wb <= 1'b0;
      rd_wb       <= '0;
      wb_data     <= '0;
    end else if (capture) begin
      valid_wb    <= valid_mem;
      regWrite_wb <= regWrite_mem && valid_mem && (rd_mem != '0);
      rd_wb       <= rd_mem;
      wb_data     <= wb_data_next;
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  logic retire;

  assign retire = capture && valid_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count <= '0;
      retire_pulse <= 1'b0;
    end else begin
      retire_pulse <= retire;
      if (retire) begin
        retire_count <= retire_count + 32'd1;
      end
    end
  end
`endif

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_stage : directed self-checking bench for wb_stage
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall_wb, flush_mem, valid_mem, regWrite_mem;
  logic [4:0]  rd_mem;
  logic [1:0]  wb_sel_mem, mem_size_mem, addr_lo_mem;
  logic        load_signed_mem;
  logic [31:0] alu_result_mem, load_data_mem, pc_plus8_mem;
  logic        valid_wb, regWrite_wb;
  logic [4:0]  rd_wb;
  logic [31:0] wb_data;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_count;
  logic        retire_pulse;
`endif

  int checks = 0;
  int errors = 0;

  logic [38:0] got;
  assign got = {valid_wb, regWrite_wb, rd_wb, wb_data};

  always #5 clk = ~clk;

  wb_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall_wb        (stall_wb),
    .flush_mem       (flush_mem),
    .valid_mem       (valid_mem),
    .regWrite_mem    (regWrite_mem),
    .rd_mem          (rd_mem),
    .wb_sel_mem      (wb_sel_mem),
    .mem_size_mem    (mem_size_mem),
    .load_signed_mem (load_signed_mem),
    .addr_lo_mem     (addr_lo_mem),
    .alu_result_mem  (alu_result_mem),
    .load_data_mem   (load_data_mem),
    .pc_plus8_mem    (pc_plus8_mem),
    .valid_wb        (valid_wb),
    .regWrite_wb     (regWrite_wb),
    .rd_wb           (rd_wb),
    .wb_data         (wb_data)
`ifdef WB_RETIRE_COUNT_EN
    ,
    .retire_count    (retire_count),
    .retire_pulse    (retire_pulse)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [1:0] size,
                       input logic sgn, input logic [1:0] lo,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic [31:0] pc);
    valid_mem = v; regWrite_mem = rw; rd_mem = rd; wb_sel_mem = sel;
    mem_size_mem = size; load_signed_mem = sgn; addr_lo_mem = lo;
    alu_result_mem = alu; load_data_mem = ld; pc_plus8_mem = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_wb = 1'b0; flush_mem = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 2'b00, 2'b10, 1'b0, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    step(); step();
    checks++;
    if (got !== 39'd0) begin
      errors++; $display("FAIL reset: got %h expected %h", got, 39'd0);
    end
    reset = 1'b0;
    drive(1'b0, 1'b1, 5'd9, 2'b00, 2'b10, 1'b0, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    step();
    checks++;
    if ({regWrite_wb, valid_wb} !== 2'b00) begin
      errors++; $display("FAIL idle_no_write: got rw=%b v=%b expected 0 0", regWrite_wb, valid_wb);
    end
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, 5'd7, 2'b00, 2'b10, 1'b0, 2'd0, 32'h12345678, 32'h0, 32'h0);
    #1;
    checks++;
    if (regWrite_wb !== 1'b0) begin
      errors++; $display("FAIL alu_latency: got rw=%b expected 0 before edge", regWrite_wb);
    end
    step();
    checks++;
    if (got !== {1'b1, 1'b1, 5'd7, 32'h12345678}) begin
      errors++; $display("FAIL alu_wb: got %h expected %h", got, {1'b1, 1'b1, 5'd7, 32'h12345678});
    end
  endtask

  task automatic test_loads();
    logic [1:0]  sz  [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b01};
    logic        sg  [7] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
    logic [1:0]  lo  [7] = '{2'd0,  2'd2,  2'd2,  2'd0,  2'd3,  2'd1,  2'd1};
    logic [31:0] exp [7] = '{32'hFFFFFF80, 32'h0000007F, 32'h00007F01, 32'h000080FF,
                             32'h80FF7F01, 32'h80FF7F01, 32'hFFFF80FF};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 5'd3, 2'b01, sz[i], sg[i], lo[i], 32'h11111111, 32'h80FF7F01, 32'h0);
      step();
      checks++;
      if (wb_data !== exp[i]) begin
        errors++; $display("FAIL load_%0d: got %h expected %h", i, wb_data, exp[i]);
      end
    end
    drive(1'b1, 1'b1, 5'd4, 2'b01, 2'b00, 1'b1, 2'd3, 32'h0, 32'h80FF7F01, 32'h0);
    step();
    checks++;
    if (wb_data !== 32'h00000001) begin
      errors++; $display("FAIL load_byte3: got %h expected %h", wb_data, 32'h00000001);
    end
  endtask

  task automatic test_select();
    drive(1'b1, 1'b1, 5'd31, 2'b10, 2'b10, 1'b0, 2'd0, 32'hAAAA5555, 32'h0, 32'h00001008);
    step();
    checks++;
    if (got !== {1'b1, 1'b1, 5'd31, 32'h00001008}) begin
      errors++; $display("FAIL link: got %h expected %h", got, {1'b1, 1'b1, 5'd31, 32'h00001008});
    end
    drive(1'b1, 1'b1, 5'd5, 2'b11, 2'b10, 1'b0, 2'd0, 32'hAAAA5555, 32'h80FF7F01, 32'h1008);
    step();
    checks++;
    if (wb_data !== 32'h0) begin
      errors++; $display("FAIL reserved_sel: got %h expected %h", wb_data, 32'h0);
    end
  endtask

  task automatic test_r0();
    drive(1'b1, 1'b1, 5'd0, 2'b00, 2'b10, 1'b0, 2'd0, 32'h55, 32'h0, 32'h0);
    step();
    checks++;
    if (got !== {1'b1, 1'b0, 5'd0, 32'h55}) begin
      errors++; $display("FAIL r0_suppress: got %h expected %h", got, {1'b1, 1'b0, 5'd0, 32'h55});
    end
    drive(1'b0, 1'b1, 5'd12, 2'b00, 2'b10, 1'b0, 2'd0, 32'h66, 32'h0, 32'h0);
    step();
    checks++;
    if (got !== {1'b0, 1'b0, 5'd12, 32'h66}) begin
      errors++; $display("FAIL invalid_no_write: got %h expected %h", got, {1'b0, 1'b0, 5'd12, 32'h66});
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 1'b1, 5'd10, 2'b00, 2'b10, 1'b0, 2'd0, 32'hCAFE0001, 32'h0, 32'h0);
    step();
    stall_wb = 1'b1;
    drive(1'b1, 1'b1, 5'd20, 2'b00, 2'b10, 1'b0, 2'd0, 32'hBEEF0002, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (got !== {1'b1, 1'b1, 5'd10, 32'hCAFE0001}) begin
        errors++; $display("FAIL stall_hold_%0d: got %h expected %h", i, got, {1'b1, 1'b1, 5'd10, 32'hCAFE0001});
      end
    end
    flush_mem = 1'b1;
    step();
    checks++;
    if (got !== 39'd0) begin
      errors++; $display("FAIL stall_flush: got %h expected %h", got, 39'd0);
    end
    stall_wb = 1'b0; flush_mem = 1'b0;
    step();
    flush_mem = 1'b1;
    step();
    checks++;
    if (got !== 39'd0) begin
      errors++; $display("FAIL flush: got %h expected %h", got, 39'd0);
    end
    flush_mem = 1'b0;
    step();
    stall_wb = 1'b1;
    step();
    reset = 1'b1;
    step();
    checks++;
    if (got !== 39'd0) begin
      errors++; $display("FAIL reset_in_stall: got %h expected %h", got, 39'd0);
    end
    reset = 1'b0; stall_wb = 1'b0;
  endtask

`ifdef WB_RETIRE_COUNT_EN
  task automatic test_retire();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 1'b1, 5'd1, 2'b00, 2'b10, 1'b0, 2'd0, 32'h1, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (retire_pulse !== 1'b1) begin
      errors++; $display("FAIL retire_pulse: got %b expected 1", retire_pulse);
    end
    stall_wb = 1'b1;
    step();
    stall_wb = 1'b0; flush_mem = 1'b1;
    step();
    flush_mem = 1'b0;
    checks++;
    if ({retire_pulse, retire_count} !== {1'b0, 32'd5}) begin
      errors++; $display("FAIL retire_count: got pulse=%b count=%0d expected pulse=0 count=5", retire_pulse, retire_count);
    end
    @(negedge clk);
    force dut.retire_count = 32'hFFFFFFFF;
    #1;
    release dut.retire_count;
    step();
    checks++;
    if (retire_count !== 32'd0) begin
      errors++; $display("FAIL retire_wrap: got %h expected %h", retire_count, 32'd0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_select();
    test_r0();
    test_stall_flush();
`ifdef WB_RETIRE_COUNT_EN
    test_retire();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb_stage
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback-select stage of the 5-stage integer pipeline.
- It is the producer side of the WB-to-EX forwarding path. Each cycle it drives regWrite_wb, rd_wb and wb_data, which feed the register-file write port and the WB-to-EX hazard/forward compare.
- It captures MEM-stage results, aligns and extends load data, selects the final writeback value, and honours pipeline stall/flush.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_wb  in  1  hold the current WB contents.
- flush_mem  in  1  replace the incoming MEM instruction with a bubble.
- valid_mem  in  1  MEM stage holds a real instruction.
- regWrite_mem  in  1  MEM instruction writes a register.
- rd_mem  in  5  destination register, bits [0:4].
- wb_sel_mem  in  2  writeback source: 00 ALU, 01 load, 10 link.
- mem_size_mem  in  2  load size: 00 byte, 01 half, 10 word.
- load_signed_mem  in  1  sign-extend loads.
- addr_lo_mem  in  2  effective-address bits [30:31].
- alu_result_mem  in  XLEN  ALU result.
- load_data_mem  in  XLEN  raw memory word, big-endian, byte 0 = bits [0:7].
- pc_plus8_mem  in  XLEN  link value.
- valid_wb  out  1  WB holds a real instruction.
- regWrite_wb  out  1  register-file write enable.
- rd_wb  out  5  write address.
- wb_data  out  XLEN  write data.

Behaviour:
- Reset: on a rising edge with reset=1, valid_wb=0, regWrite_wb=0, rd_wb=0, wb_data=0. Reset overrides stall and flush, including mid-stall.
- Latency: one cycle. MEM inputs sampled at edge N appear on the WB outputs after edge N. The outputs are registered, with no combinational path from input to output.
- Priority each edge: reset > flush_mem > stall_wb > capture.
- flush_mem=1: load a bubble (valid_wb=0, regWrite_wb=0, rd_wb=0, wb_data=0). This applies even when stall_wb=1.
- stall_wb=1 with no flush: all outputs hold. The register file may rewrite the same value; this is harmless.
- Capture: valid_wb<=valid_mem; rd_wb<=rd_mem; regWrite_wb<=regWrite_mem & valid_mem & (rd_mem!=0).
- r0 writes are suppressed so the forwarding compare never matches r0.
- wb_data select:
  - wb_sel=00: alu_result.
  - wb_sel=10: pc_plus8.
  - wb_sel=11: reserved, gives 0.
  - wb_sel=01: aligned load data.
- Load alignment:
  - byte: lane = addr_lo (0 selects bits [0:7], 3 selects bits [24:31]). Zero- or sign-extend to 32 bits.
  - half: lane = addr_lo[30] (0 selects [0:15], 1 selects [16:31]); addr_lo[31] is ignored. Then extend.
  - word: addr_lo is ignored.
  - mem_size=11: treated as word.
- Data is computed before the register, so the select logic adds no delay on the WB outputs.
- valid_mem=0 yields regWrite_wb=0 regardless of regWrite_mem.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- When defined, add two output ports:
  - retire_count (32): increments on every edge where the capture path loads valid_mem=1 (not on stall, flush or reset). Wraps from 0xFFFFFFFF to 0. Cleared by reset.
  - retire_pulse (1): registered copy of that increment condition.
- When undefined, neither port nor the counter exists, and the rest of the behaviour is unchanged.

Decomposition:
- Shared package pipe_pkg holds:
  - WB_SEL_ALU/LOAD/LINK constants.
  - MEM_SIZE_BYTE/HALF/WORD constants.
  - REG_AW and XLEN.
- One combinational sub-module, load_align: inputs raw word, size, signed flag and addr_lo; output is the extended 32-bit value. It is reusable by the future cache-bypass path.
- The pipeline register and select logic stay in wb_stage.

Test Plan:
- Reset then idle: reset held 2 cycles, then valid_mem=0 → all outputs 0; regWrite_wb stays 0.
- ALU writeback: rd=7, regWrite=1, wb_sel=00, alu=0x12345678 → next cycle rd_wb=7, regWrite_wb=1, wb_data=0x12345678.
- Load alignment with load_data_mem=0x80FF7F01:
  - signed byte, addr_lo=0 → 0xFFFFFF80.
  - unsigned byte, addr_lo=2 → 0x0000007F.
  - signed half, addr_lo=2 → 0x00007F01.
  - unsigned half, addr_lo=0 → 0x000080FF.
- r0 suppression: rd=0, regWrite=1 → regWrite_wb=0, valid_wb=1.
- Stall and flush:
  - stall_wb=1 for 3 cycles → outputs unchanged.
  - stall_wb=1 and flush_mem=1 on the same edge → bubble, all outputs 0.
  - reset asserted during a stall → all outputs 0 at the next edge.
- With WB_RETIRE_COUNT_EN: 5 valid captures, 1 stall, 1 flush → retire_count=5. Counter preset via force to 0xFFFFFFFF plus one capture → 0.
